// File: rtl/tetris_pf_pkg.sv
// Shared constants and types for the playfield tile engine.
// Register map, STATUS bit positions and cell template type.
package tetris_pf_pkg;

  localparam int PF_CELL_BITS = 2;

  typedef logic [PF_CELL_BITS-1:0] cell_t;

  localparam cell_t WHITE_TEMPLATE = '1;

  localparam logic [7:0] A_CTRL    = 8'h40;
  localparam logic [7:0] A_FMASK   = 8'h41;
  localparam logic [7:0] A_FFRAMES = 8'h42;
  localparam logic [7:0] A_STATUS  = 8'h43;

  localparam int ST_PEND    = 0;
  localparam int ST_ACTIVE  = 1;
  localparam int ST_FRONT   = 2;
  localparam int ST_REM_LSB = 8;

endpackage

// File: rtl/pf_row_ram.sv
// Dual-port row store: port A for the bus, port B for the beam.
// Both ports have a one-cycle registered read.
module pf_row_ram #(
  parameter int AW = 6,
  parameter int DW = 20
) (
  input  logic          i_clk,
  input  logic          i_a_we,
  input  logic          i_a_re,
  input  logic [3:0]    i_a_be,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wd,
  output logic [DW-1:0] o_a_rd,
  input  logic [AW-1:0] i_b_addr,
  output logic [DW-1:0] o_b_rd
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_a_we) begin
      for (int b = 0; b < DW; b++) begin
        if (i_a_be[b/8]) r_mem[i_a_addr][b] <= i_a_wd[b];
      end
    end
    // Port A holds its data between reads
    if (i_a_re) o_a_rd <= r_mem[i_a_addr];
    o_b_rd <= r_mem[i_b_addr];
  end

endmodule

// File: rtl/playfield_tile_engine.sv
// Double-buffered tile playfield with vblank page flip,
// row-flash animation and a 2-cycle pixel lookup pipeline.
module playfield_tile_engine
  import tetris_pf_pkg::*;
#(
  parameter int COLS          = 10,
  parameter int ROWS          = 20,
  parameter int CELL_BITS     = PF_CELL_BITS,
  parameter int TILE_LOG2     = 4,
  parameter int ORIGIN_X_TILE = 12,
  parameter int ORIGIN_Y_TILE = 5,
  parameter int FLASH_HALF    = 4,
  parameter int ADDR_W        = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 AVL_READ,
  input  logic                 AVL_WRITE,
  input  logic                 AVL_CS,
  input  logic [3:0]           AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]    AVL_ADDR,
  input  logic [31:0]          AVL_WRITEDATA,
  output logic [31:0]          AVL_READDATA,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 pix_valid,
  input  logic                 frame_start,
  output logic [CELL_BITS-1:0] cell_template,
  output logic                 in_board,
  output logic [TILE_LOG2-1:0] tile_px,
  output logic [TILE_LOG2-1:0] tile_py,
  output logic                 out_valid,
  output logic                 swap_done,
  output logic                 flash_done
);

  localparam int ROW_W = COLS * CELL_BITS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int HW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [9:0] L_X0 = 10'(ORIGIN_X_TILE);
  localparam logic [9:0] L_X1 = 10'(ORIGIN_X_TILE + COLS);
  localparam logic [9:0] L_Y0 = 10'(ORIGIN_Y_TILE);
  localparam logic [9:0] L_Y1 = 10'(ORIGIN_Y_TILE + ROWS);

  logic                 r_front;
  logic                 r_pend;
  logic [7:0]           r_cnt;
  logic [HW-1:0]        r_half;
  logic                 r_phase;
  logic [ROWS-1:0]      r_mask;
  logic                 r_rd_row;
  logic [31:0]          r_csr;
  logic                 r1_valid;
  logic                 r1_hit;
  logic                 r1_flash;
  logic [CW-1:0]        r1_col;
  logic [TILE_LOG2-1:0] r1_px;
  logic [TILE_LOG2-1:0] r1_py;

  logic                 w_wr;
  logic                 w_rd;
  logic                 w_row_hit;
  logic                 w_swap_req;
  logic                 w_ff_wr;
  logic                 w_mask_wr;
  logic                 w_flash_end;
  logic [ROWS-1:0]      w_mask_nx;
  logic [31:0]          w_csr;
  logic [ROW_W-1:0]     w_qa;
  logic [ROW_W-1:0]     w_qb;
  logic [ROW_W-1:0]     w_sh;
  logic [9:0]           w_tx;
  logic [9:0]           w_ty;
  logic [9:0]           w_dx;
  logic [9:0]           w_dy;
  logic                 w_hit;
  logic [CW-1:0]        w_col;
  logic [RW-1:0]        w_row;
  logic                 w_unused;

  assign w_wr = AVL_WRITE & AVL_CS;
  assign w_rd = AVL_READ & AVL_CS;
  assign w_row_hit = AVL_ADDR < ADDR_W'(ROWS);
  assign w_swap_req = w_wr && AVL_ADDR == ADDR_W'(A_CTRL)
                      && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign w_ff_wr = w_wr && AVL_ADDR == ADDR_W'(A_FFRAMES)
                   && AVL_BYTE_EN[0];
  assign w_mask_wr = w_wr && AVL_ADDR == ADDR_W'(A_FMASK);
  assign w_flash_end = frame_start && r_cnt == 8'd1 && !w_ff_wr;

  always_comb begin
    w_mask_nx = r_mask;
    for (int r = 0; r < ROWS; r++) begin
      if (AVL_BYTE_EN[r/8]) w_mask_nx[r] = AVL_WRITEDATA[r];
    end
  end

  always_comb begin
    w_csr = '0;
    if (AVL_ADDR == ADDR_W'(A_FMASK)) w_csr = 32'(r_mask);
    if (AVL_ADDR == ADDR_W'(A_FFRAMES)) w_csr = 32'(r_cnt);
    if (AVL_ADDR == ADDR_W'(A_STATUS)) begin
      w_csr[ST_PEND]             = r_pend;
      w_csr[ST_ACTIVE]           = r_cnt != 8'd0;
      w_csr[ST_FRONT]            = r_front;
      w_csr[ST_REM_LSB +: 8]     = r_cnt;
    end
  end

  assign AVL_READDATA = r_rd_row ? 32'(w_qa) : r_csr;

  assign w_tx = DrawX >> TILE_LOG2;
  assign w_ty = DrawY >> TILE_LOG2;
  assign w_dx = w_tx - L_X0;
  assign w_dy = w_ty - L_Y0;
  assign w_col = w_dx[CW-1:0];
  assign w_row = w_dy[RW-1:0];
  assign w_hit = (w_tx >= L_X0) && (w_tx < L_X1)
                 && (w_ty >= L_Y0) && (w_ty < L_Y1);
  assign w_sh = w_qb >> (r1_col * CELL_BITS);
  assign w_unused = ^{AVL_WRITEDATA, w_dx, w_dy, w_sh};

  pf_row_ram #(
    .AW (RW + 1),
    .DW (ROW_W)
  ) u_ram (
    .i_clk    (CLK),
    .i_a_we   (w_wr & w_row_hit),
    .i_a_re   (w_rd & w_row_hit),
    .i_a_be   (AVL_BYTE_EN),
    .i_a_addr ({~r_front, AVL_ADDR[RW-1:0]}),
    .i_a_wd   (AVL_WRITEDATA[ROW_W-1:0]),
    .o_a_rd   (w_qa),
    .i_b_addr ({r_front, w_row}),
    .o_b_rd   (w_qb)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_front    <= 1'b0;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      r_half     <= '0;
      r_phase    <= 1'b0;
      r_mask     <= '0;
      r_rd_row   <= 1'b0;
      r_csr      <= '0;
      swap_done  <= 1'b0;
      flash_done <= 1'b0;
    end else begin
      swap_done  <= frame_start & r_pend;
      flash_done <= w_flash_end;
      if (frame_start & r_pend) r_front <= ~r_front;
      // A request in the flip cycle waits for the next vblank
      if (w_swap_req) r_pend <= 1'b1;
      else if (frame_start) r_pend <= 1'b0;
      if (w_ff_wr) begin
        r_cnt   <= AVL_WRITEDATA[7:0];
        r_half  <= '0;
        r_phase <= 1'b0;
      end else if (frame_start && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
        if (r_half == HW'(FLASH_HALF - 1)) begin
          r_half  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_half <= r_half + 1'b1;
        end
      end
      if (w_mask_wr) r_mask <= w_mask_nx;
      else if (w_flash_end) r_mask <= '0;
      if (w_rd) begin
        r_rd_row <= w_row_hit;
        r_csr    <= w_csr;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r1_valid      <= 1'b0;
      r1_hit        <= 1'b0;
      r1_flash      <= 1'b0;
      r1_col        <= '0;
      r1_px         <= '0;
      r1_py         <= '0;
      out_valid     <= 1'b0;
      in_board      <= 1'b0;
      cell_template <= '0;
      tile_px       <= '0;
      tile_py       <= '0;
    end else begin
      r1_valid  <= pix_valid;
      r1_hit    <= w_hit;
      r1_flash  <= w_hit && r_phase && r_cnt != 8'd0
                   && r_mask[w_row];
      r1_col    <= w_col;
      r1_px     <= DrawX[TILE_LOG2-1:0];
      r1_py     <= DrawY[TILE_LOG2-1:0];
      out_valid <= r1_valid;
      in_board  <= r1_hit;
      tile_px   <= r1_px;
      tile_py   <= r1_py;
      if (!r1_hit) cell_template <= '0;
      else if (r1_flash) cell_template <= '1;
      else cell_template <= w_sh[CELL_BITS-1:0];
    end
  end

endmodule
